// File: rtl/vector_deserializer_if.sv
// Stream-in / vector-out bundle for the M31 deserializer.
// The slave side is the deserializer; the master side drives words and consumes vectors.
interface vector_deserializer_if #(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16
);
    logic [WORD_WIDTH-1:0]                  in_word;
    logic                                   in_valid;
    logic                                   in_first;
    logic                                   in_ready;
    logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] out_vec;
    logic                                   out_valid;
    logic                                   out_ready;
    logic                                   err;

    modport master (
        output in_word, in_valid, in_first, out_ready,
        input  in_ready, out_vec, out_valid, err
    );

    modport slave (
        input  in_word, in_valid, in_first, out_ready,
        output in_ready, out_vec, out_valid, err
    );
endinterface

// File: rtl/vector_deserializer.sv
// Assembles a stream of M31 words into a VECTOR_SIZE-element vector, with a fill bank
// so the next vector can load while the previous one is held for the consumer.
module vector_deserializer #(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    vector_deserializer_if.slave   bus
);
    localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

    typedef logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec_t;
    typedef enum logic {FILL, HOLD} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    vec_t                  fillBank_q, fillBank_d;
    vec_t                  outBank_q, outBank_d;
    logic                  outValid_q, outValid_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  outFree;
    logic [WORD_WIDTH-1:0] canonWord;

    // p = 2^31-1 is the only non-canonical 31-bit value; it folds to zero.
    assign canonWord = (bus.in_word == {WORD_WIDTH{1'b1}}) ? '0 : bus.in_word;

    assign bus.in_ready  = (state_q == FILL) && rst_n;
    assign bus.out_vec   = outBank_q;
    assign bus.out_valid = outValid_q;
    assign bus.err       = err_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign outFree = !outValid_q || bus.out_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fillBank_d = fillBank_q;
        outBank_d  = outBank_q;
        outValid_d = outValid_q;
        err_d      = 1'b0;

        // A transfer empties O unless a reload below refills it in the same cycle.
        if (outValid_q && bus.out_ready) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (bus.in_first) begin
                        fillBank_d[0] = canonWord;
                        idx_d         = IDX_W'(1);
                        err_d         = (idx_q != '0);
                    end else if (idx_q == LAST_IDX) begin
                        fillBank_d[LAST_IDX] = canonWord;
                        idx_d                = '0;
                        if (outFree) begin
                            outBank_d  = fillBank_d;
                            outValid_d = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        fillBank_d[idx_q] = canonWord;
                        idx_d             = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (outFree) begin
                    outBank_d  = fillBank_q;
                    outValid_d = 1'b1;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL;
            idx_q      <= '0;
            fillBank_q <= '0;
            outBank_q  <= '0;
            outValid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            fillBank_q <= fillBank_d;
            outBank_q  <= outBank_d;
            outValid_q <= outValid_d;
            err_q      <= err_d;
        end
    end
endmodule
